// File: rtl/lcm_cal_if.sv
// Start/busy/done handshake and operand/result bundle for the LCM engine.
interface lcm_cal_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned RW = 2 * W
);
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [RW-1:0] l;
  logic          zero;

  modport master (output start, a, b, input busy, done, l, zero);
  modport slave  (input start, a, b, output busy, done, l, zero);
endinterface

// File: rtl/lcm_cal.sv
// Sequential LCM engine: grows multiples of A and B by repeated addition
// until they meet; the meeting value is LCM(A,B).
module lcm_cal #(
  parameter int unsigned W = 4
) (
  input  logic      clk,
  input  logic      rst,
  lcm_cal_if.slave  bus_if
);
  localparam int unsigned RW = 2 * W;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [RW-1:0] ma_q, ma_d, mb_q, mb_d;
  logic [RW-1:0] l_q, l_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          zero_q, zero_d;
  logic          op_zero_c;

  assign op_zero_c = (bus_if.a == '0) || (bus_if.b == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus_if.start && !op_zero_c) state_d = S_RUN;
      S_RUN:  if (ma_q == mb_q)               state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    ra_d   = ra_q;
    rb_d   = rb_q;
    ma_d   = ma_q;
    mb_d   = mb_q;
    l_d    = l_q;
    busy_d = busy_q;
    done_d = 1'b0;
    zero_d = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus_if.start) begin
          if (op_zero_c) begin
            done_d = 1'b1;
            l_d    = '0;
            zero_d = 1'b1;
          end else begin
            ra_d   = RW'(bus_if.a);
            rb_d   = RW'(bus_if.b);
            ma_d   = RW'(bus_if.a);
            mb_d   = RW'(bus_if.b);
            busy_d = 1'b1;
            zero_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        // Advance whichever multiple is behind; they can never exceed LCM.
        if (ma_q == mb_q) begin
          l_d    = ma_q;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else if (ma_q < mb_q) begin
          ma_d = ma_q + ra_q;
        end else begin
          mb_d = mb_q + rb_q;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_q   <= '0;
      rb_q   <= '0;
      ma_q   <= '0;
      mb_q   <= '0;
      l_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ra_q   <= ra_d;
      rb_q   <= rb_d;
      ma_q   <= ma_d;
      mb_q   <= mb_d;
      l_q    <= l_d;
      busy_q <= busy_d;
      done_q <= done_d;
      zero_q <= zero_d;
    end
  end

  assign bus_if.busy = busy_q;
  assign bus_if.done = done_q;
  assign bus_if.l    = l_q;
  assign bus_if.zero = zero_q;
endmodule

// File: tb/tb_lcm_cal.sv
// Directed bench for lcm_cal: hand-computed LCM results, latencies and
// handshake corner cases.
module tb_lcm_cal;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  lcm_cal_if #(.W(4)) bus_if ();

  lcm_cal #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One start pulse; exp_edge is the edge after which done is first seen,
  // counting the accepting edge as 0. Busy cycles equal exp_edge as well.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int exp_l, input int exp_zero, input int exp_edge);
    int k;
    int busy_cnt;
    bus_if.a     = a;
    bus_if.b     = b;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.a     = 4'hx;
    bus_if.b     = 4'hx;
    chk({tag, "_zero_at_accept"}, 32'(bus_if.zero), 32'(exp_zero));
    k = 0;
    busy_cnt = 0;
    while (!bus_if.done && k < 100) begin
      if (bus_if.busy) busy_cnt++;
      tick();
      k++;
    end
    chk({tag, "_done_edge"}, 32'(k), 32'(exp_edge));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_edge));
    chk({tag, "_l"}, 32'(bus_if.l), 32'(exp_l));
    chk({tag, "_zero"}, 32'(bus_if.zero), 32'(exp_zero));
    tick();
    chk({tag, "_done_one_cycle"}, 32'(bus_if.done), 32'd0);
    chk({tag, "_l_hold"}, 32'(bus_if.l), 32'(exp_l));
  endtask

  initial begin
    int k;
    int dcnt;
    bus_if.start = 1'b0;
    bus_if.a     = 4'd0;
    bus_if.b     = 4'd0;
    #1;
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_done", 32'(bus_if.done), 32'd0);
    chk("rst_l",    32'(bus_if.l),    32'd0);
    chk("rst_zero", 32'(bus_if.zero), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    run_op("op_4_6", 4'd4, 4'd6, 12, 0, 4);

    // Abort mid-run
    bus_if.a = 4'd15;
    bus_if.b = 4'd14;
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    repeat (10) tick();
    chk("abort_busy_before", 32'(bus_if.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus_if.busy), 32'd0);
    chk("abort_l",    32'(bus_if.l),    32'd0);
    chk("abort_done", 32'(bus_if.done), 32'd0);
    tick();
    rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_if.done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    run_op("op_3_5", 4'd3, 4'd5, 15, 0, 7);

    run_op("op_15_14", 4'd15, 4'd14, 210, 0, 28);
    run_op("op_14_15", 4'd14, 4'd15, 210, 0, 28);
    run_op("op_5_5",   4'd5,  4'd5,  5,   0, 1);
    run_op("op_1_9",   4'd1,  4'd9,  9,   0, 9);
    run_op("op_0_7",   4'd0,  4'd7,  0,   1, 0);
    run_op("op_2_3",   4'd2,  4'd3,  6,   0, 4);

    // Start held high across a run; operands change after acceptance
    bus_if.a = 4'd2;
    bus_if.b = 4'd3;
    bus_if.start = 1'b1;
    tick();
    tick();
    bus_if.a = 4'd4;
    bus_if.b = 4'd10;
    k = 1;
    while (!bus_if.done && k < 100) begin
      tick();
      k++;
    end
    chk("b2b_first_edge", 32'(k), 32'd4);
    chk("b2b_first_l",    32'(bus_if.l), 32'd6);
    tick();
    bus_if.start = 1'b0;
    chk("b2b_second_busy", 32'(bus_if.busy), 32'd1);
    chk("b2b_second_done_low", 32'(bus_if.done), 32'd0);
    k = 0;
    tick();
    k++;
    bus_if.a = 4'd3;
    bus_if.b = 4'd3;
    bus_if.start = 1'b1;
    tick();
    k++;
    bus_if.start = 1'b0;
    while (!bus_if.done && k < 100) begin
      tick();
      k++;
    end
    chk("b2b_second_edge", 32'(k), 32'd6);
    chk("b2b_second_l",    32'(bus_if.l), 32'd20);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.done) dcnt++;
    end
    chk("b2b_no_extra_done", 32'(dcnt), 32'd0);
    chk("b2b_l_hold", 32'(bus_if.l), 32'd20);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/lcm_cal.md
Name: lcm_cal

Overview:
- Sequential least-common-multiple engine. It is the additive dual of the subtractive GCD datapath: the GCD block reduces operands by repeated subtraction, while this block grows two multiples by repeated addition until they meet.
- Takes two 4-bit unsigned operands A and B and returns LCM(A,B) as an 8-bit value.
- Uses a start/busy/done handshake so a controller can issue operand pairs back-to-back.

Parameters:
- W, 4: operand width in bits.
- RW, 8: result width in bits; fixed at 2*W.

Ports:
- clk  input  1  single system clock, rising edge active.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  W  operand A, unsigned; sampled on the accepting edge.
- B  input  W  operand B, unsigned; sampled on the accepting edge.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse marking the cycle in which L becomes valid.
- L  output  RW  result; holds its value until the next accepted start.
- zero  output  1  high with done when either operand was 0; holds with L.

Behaviour:
- Reset (async, active-high): state=IDLE, busy=0, done=0, L=0, zero=0. Internal ra, rb, ma, mb all cleared.
- Reset asserted mid-computation aborts the operation. No done pulse is produced for the aborted request.
- States: IDLE, RUN.
- IDLE with start=1, and A or B equal to 0:
  - done<=1, L<=0, zero<=1, busy stays 0, state stays IDLE.
  - The result is visible one cycle after the accepting edge.
- IDLE with start=1, A and B both non-zero:
  - ra<=A, rb<=B, ma<=A, mb<=B (zero-extended to RW bits).
  - busy<=1, zero<=0, done<=0, state<=RUN.
- RUN, one action per clock edge:
  - ma==mb: L<=ma, done<=1, busy<=0, state<=IDLE.
  - ma<mb: ma<=ma+ra.
  - ma>mb: mb<=mb+rb.
- done is high for exactly one cycle. It is cleared on the next edge unless a new zero-operand start is accepted in IDLE on that same edge.
- Latency: let N be the number of additions (N = LCM/A + LCM/B - 2).
  - done is high in the cycle following edge N+1, counting the accepting edge as edge 0.
  - busy is high from edge 0 to edge N+1.
  - Worst case is A=15, B=14: N=27.
- Width and overflow: ma and mb never exceed LCM, and LCM is at most 210, so RW=8 cannot overflow. No saturation logic is needed.
- Boundary conditions:
  - start while busy is ignored. Operands are not resampled.
  - start in the same cycle done is high is accepted, because the state is IDLE.
  - A and B may change freely after the accepting edge.
  - A==B completes with N=0.
- Result hold: L and zero hold their value after done until the next accepted start. A non-zero start clears zero on its accepting edge.

Test Plan:
- Reset: assert rst mid-RUN (A=15, B=14, after 10 cycles) -> outputs go to 0 immediately. After release, no done pulse appears. A new start A=3, B=5 then yields L=15.
- A=4, B=6, start one cycle -> busy high for 4 cycles, done pulses after edge 4, L=12, zero=0.
- A=15, B=14 -> done after edge 28, L=210 (0xD2). Repeat for A=14, B=15 with identical timing.
- A=5, B=5 -> done after edge 1, L=5. A=1, B=9 -> L=9 after edge 9.
- A=0, B=7 -> done after edge 0, L=0, zero=1, busy never high. Next start A=2, B=3 clears zero and gives L=6.
- Back-to-back and ignored starts:
  - Hold start high continuously with A=2, B=3 changing to A=4, B=10 mid-run -> first result is L=6.
  - The second start is accepted in the done cycle -> L=20.
  - A pulse of start during busy has no effect.
